popcount_accumulator: RTL and testbench
=======================================

# popcount_accumulator

Downstream stage of the 4-input popcount block. Consumes its one-hot count outputs (v..z, meaning 0..4 set bits) on every enabled cycle and accumulates them over a fixed window of WINDOW samples. At the end of each window it presents the window total on a registered output with a valid/ready handshake. It flags malformed (non-one-hot) inputs and results dropped under backpressure.

## Interface
Parameters:
- WINDOW, default 16: samples per window; legal range 1..255.
- SUM_W, default 7: width of the window sum; must satisfy 2^SUM_W > 4*WINDOW. The default holds 0..64.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  sample enable; a sample is accepted on each rising edge where ena=1.
- v  in  1  one-hot count = 0.
- w  in  1  one-hot count = 1.
- x  in  1  one-hot count = 2.
- y  in  1  one-hot count = 3.
- z  in  1  one-hot count = 4.
- sum_ready  in  1  consumer ready; completes the handshake when high together with sum_valid.
- sum_out  out  SUM_W  window total; stable while sum_valid=1.
- sum_valid  out  1  sum_out holds an unconsumed window total.
- overrun  out  1  sticky; a completed window was dropped.
- onehot_err  out  1  sticky; an accepted sample was not exactly one-hot.

## Operation
- **Decode:** exactly one of {v,w,x,y,z} high gives a value of 0,1,2,3,4 respectively. Any other pattern (none high, or several high) gives value 0 and sets onehot_err.
- **Internal state:**
  - acc, SUM_W bits: partial sum.
  - cnt, 8 bits: samples accepted in the current window.
  - Two-state output FSM: EMPTY (sum_valid=0) and FULL (sum_valid=1).
- **Accepted sample (ena=1):** the value is added to the window.
  - If cnt < WINDOW-1: acc <= acc + value; cnt <= cnt + 1.
  - If cnt == WINDOW-1 (window completes): final = acc + value; acc <= 0; cnt <= 0. Accumulation continues with no idle cycle between windows.
- **ena=0:** acc, cnt and onehot_err hold. v..z are ignored. The handshake still operates.
- **Output FSM:**
  - EMPTY + window completes: sum_out <= final; go to FULL.
  - FULL + sum_ready=1 + no completion: go to EMPTY; sum_out holds its last value.
  - FULL + sum_ready=1 + completion on the same edge: sum_out <= final; stay FULL. This is not an overrun.
  - FULL + sum_ready=0 + completion: final is discarded; sum_out unchanged; overrun <= 1; stay FULL.
  - FULL + sum_ready=0 + no completion: hold.
- **Sticky flags:** overrun and onehot_err clear only on reset.
- **Arithmetic:** the parameter constraint guarantees no overflow. No saturation logic is required.
- **Reset** (synchronous; takes priority over every other event in that cycle): acc=0, cnt=0, FSM=EMPTY, sum_out=0, sum_valid=0, overrun=0, onehot_err=0. A reset mid-window discards the partial sum, and a reset while FULL discards the pending result.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: sum_valid rises on the same rising edge that accepts the WINDOW-th sample, i.e. it is visible the cycle after that sample is presented.
- onehot_err is visible the cycle after the bad sample is presented.
- Handshake: a transfer occurs on an edge where sum_valid=1 and sum_ready=1.
  - sum_ready may be high while sum_valid=0; this has no effect.
  - sum_out and sum_valid must not change while sum_valid=1 and sum_ready=0, except by reset.
- Throughput: one sample per cycle. With WINDOW=1 and sum_ready held high, a new sum is produced every enabled cycle.
- overrun is set on the edge of the dropped completion.

## Test plan
- **Basic window:** WINDOW=4, reset, ena=1, x high for 4 cycles, sum_ready=1 -> sum_out=8, sum_valid high for exactly 1 cycle (the cycle after the 4th sample), overrun=0, onehot_err=0.
- **Maximum sum:** default WINDOW=16, z high for 16 consecutive enabled cycles -> sum_out=64. Then v for 16 cycles -> sum_out=0, sum_valid=1 again. No flags set.
- **Enable gaps:** WINDOW=4, samples w,y,(ena=0 with z high for 3 cycles),x,w -> sum_out=7. Cycles with ena=0 are not counted.
- **Backpressure and overrun:**
  - WINDOW=2, sum_ready=0, feed 2×y then 2×z -> sum_out=6 held, overrun=1 after the 4th sample.
  - Then sum_ready=1 for one cycle -> sum_valid=0, overrun stays 1.
  - Separately: completion on the same edge as the handshake -> new sum loaded, sum_valid stays 1, overrun=0.
- **Malformed input:** WINDOW=4, samples {v&w}, w, w, w -> sum_out=3, onehot_err=1 and stays set.
- **Reset mid-window:** WINDOW=4, after 2 samples of z assert reset for 1 cycle, then feed 4×w -> sum_out=4, not 12. All outputs are 0 during the cycle after reset.

Source files
------------

// File: rtl/popcount_accumulator.sv
// rtl/popcount_accumulator.sv - windowed accumulator for one-hot popcount results
//
// Purpose: decodes the one-hot count lines v..z of the upstream popcount stage,
// sums WINDOW accepted samples and presents each window total on a registered
// valid/ready output. Flags malformed samples and totals dropped under
// backpressure.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   ena         sample enable
//   v,w,x,y,z   one-hot count lines (0,1,2,3,4)
//   sum_ready   consumer ready
//   sum_out     window total, stable while sum_valid is high
//   sum_valid   sum_out holds an unconsumed total
//   overrun     sticky: a completed window was dropped
//   onehot_err  sticky: an accepted sample was not exactly one-hot

module popcount_accumulator #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned SUM_W  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             v,
  input  logic             w,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic             sum_ready,
  output logic [SUM_W-1:0] sum_out,
  output logic             sum_valid,
  output logic             overrun,
  output logic             onehot_err
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(WINDOW - 1);

  logic [SUM_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic [SUM_W-1:0] r_sum_out;
  logic             r_overrun;
  logic             r_onehot_err;
  state_t           r_state;
  state_t           w_state_next;

  logic [2:0]       w_value;
  logic             w_onehot;
  logic             w_last;
  logic             w_complete;
  logic [SUM_W-1:0] w_sum;
  logic             w_load;
  logic             w_drop;

  // Decode: anything other than exactly one line high counts as zero.
  always_comb begin
    w_value  = 3'd0;
    w_onehot = 1'b1;
    case ({z, y, x, w, v})
      5'b00001: w_value = 3'd0;
      5'b00010: w_value = 3'd1;
      5'b00100: w_value = 3'd2;
      5'b01000: w_value = 3'd3;
      5'b10000: w_value = 3'd4;
      default:  w_onehot = 1'b0;
    endcase
  end

  assign w_sum      = r_acc + SUM_W'(w_value);
  assign w_last     = (r_cnt == LP_LAST);
  assign w_complete = ena & w_last;

  // Window accumulation; wraps straight into the next window on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_cnt        <= 8'd0;
      r_onehot_err <= 1'b0;
    end else if (ena) begin
      r_onehot_err <= r_onehot_err | ~w_onehot;
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= 8'd0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Output FSM: a completion coinciding with a handshake refills the slot.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_complete) begin
          w_load       = 1'b1;
          w_state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_complete) begin
          if (sum_ready) begin
            w_load = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else if (sum_ready) begin
          w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_sum_out <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_sum_out <= w_sum;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign sum_out    = r_sum_out;
  assign sum_valid  = (r_state == ST_FULL);
  assign overrun    = r_overrun;
  assign onehot_err = r_onehot_err;

endmodule

// File: tb/tb_popcount_accumulator.sv
// tb/tb_popcount_accumulator.sv - directed bench for popcount_accumulator

module tb_popcount_accumulator;

  logic clk = 1'b0;
  logic reset, ena, v, w, x, y, z, sum_ready;

  logic [6:0] s1, s2, s4, s16;
  logic       sv1, sv2, sv4, sv16;
  logic       ov1, ov2, ov4, ov16;
  logic       oe1, oe2, oe4, oe16;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] PV = 5'b00001;
  localparam logic [4:0] PW = 5'b00010;
  localparam logic [4:0] PX = 5'b00100;
  localparam logic [4:0] PY = 5'b01000;
  localparam logic [4:0] PZ = 5'b10000;

  always #5 clk = ~clk;

  popcount_accumulator #(.WINDOW(1), .SUM_W(7)) u_w1 (
    .clk(clk), .reset(reset), .ena(ena), .v(v), .w(w), .x(x), .y(y), .z(z),
    .sum_ready(sum_ready), .sum_out(s1), .sum_valid(sv1), .overrun(ov1), .onehot_err(oe1));
  popcount_accumulator #(.WINDOW(2), .SUM_W(7)) u_w2 (
    .clk(clk), .reset(reset), .ena(ena), .v(v), .w(w), .x(x), .y(y), .z(z),
    .sum_ready(sum_ready), .sum_out(s2), .sum_valid(sv2), .overrun(ov2), .onehot_err(oe2));
  popcount_accumulator #(.WINDOW(4), .SUM_W(7)) u_w4 (
    .clk(clk), .reset(reset), .ena(ena), .v(v), .w(w), .x(x), .y(y), .z(z),
    .sum_ready(sum_ready), .sum_out(s4), .sum_valid(sv4), .overrun(ov4), .onehot_err(oe4));
  popcount_accumulator #(.WINDOW(16), .SUM_W(7)) u_w16 (
    .clk(clk), .reset(reset), .ena(ena), .v(v), .w(w), .x(x), .y(y), .z(z),
    .sum_ready(sum_ready), .sum_out(s16), .sum_valid(sv16), .overrun(ov16), .onehot_err(oe16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic cyc(input logic [4:0] pat, input logic en, input logic rdy);
    {z, y, x, w, v} = pat;
    ena       = en;
    sum_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(5'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ena = 1'b0; sum_ready = 1'b0;
    {z, y, x, w, v} = 5'b0;
    #2;

    // Reset state
    do_reset();
    chk("rst_sum4", 32'(s4), 0);
    chk("rst_valid4", 32'(sv4), 0);
    chk("rst_ovr4", 32'(ov4), 0);
    chk("rst_err4", 32'(oe4), 0);

    // Basic window: WINDOW=4, 4 x 2 = 8
    do_reset();
    for (int i = 0; i < 3; i++) cyc(PX, 1'b1, 1'b1);
    chk("basic_valid_early", 32'(sv4), 0);
    cyc(PX, 1'b1, 1'b1);
    chk("basic_sum", 32'(s4), 8);
    chk("basic_valid", 32'(sv4), 1);
    cyc(5'b0, 1'b0, 1'b1);
    chk("basic_valid_drop", 32'(sv4), 0);
    chk("basic_sum_hold", 32'(s4), 8);
    chk("basic_ovr", 32'(ov4), 0);
    chk("basic_err", 32'(oe4), 0);

    // Maximum sum: WINDOW=16, 16 x 4 = 64, then 16 x 0 = 0
    do_reset();
    for (int i = 0; i < 15; i++) cyc(PZ, 1'b1, 1'b1);
    chk("max_valid_early", 32'(sv16), 0);
    cyc(PZ, 1'b1, 1'b1);
    chk("max_sum", 32'(s16), 64);
    chk("max_valid", 32'(sv16), 1);
    cyc(PV, 1'b1, 1'b1);
    chk("max_consumed", 32'(sv16), 0);
    for (int i = 0; i < 15; i++) cyc(PV, 1'b1, 1'b1);
    chk("zero_sum", 32'(s16), 0);
    chk("zero_valid", 32'(sv16), 1);
    chk("max_ovr", 32'(ov16), 0);
    chk("max_err", 32'(oe16), 0);

    // Enable gaps: w,y,(gap x3 with z),x,w -> 1+3+2+1 = 7
    do_reset();
    cyc(PW, 1'b1, 1'b1);
    cyc(PY, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(PZ, 1'b0, 1'b1);
    cyc(5'b11111, 1'b0, 1'b1);
    chk("gap_err_ignored", 32'(oe4), 0);
    cyc(PX, 1'b1, 1'b1);
    chk("gap_valid_early", 32'(sv4), 0);
    cyc(PW, 1'b1, 1'b1);
    chk("gap_sum", 32'(s4), 7);
    chk("gap_valid", 32'(sv4), 1);

    // Backpressure and overrun: WINDOW=2
    do_reset();
    cyc(PY, 1'b1, 1'b0);
    cyc(PY, 1'b1, 1'b0);
    chk("bp_sum", 32'(s2), 6);
    chk("bp_valid", 32'(sv2), 1);
    cyc(PZ, 1'b1, 1'b0);
    chk("bp_ovr_early", 32'(ov2), 0);
    cyc(PZ, 1'b1, 1'b0);
    chk("bp_ovr", 32'(ov2), 1);
    chk("bp_sum_held", 32'(s2), 6);
    chk("bp_valid_held", 32'(sv2), 1);
    cyc(5'b0, 1'b0, 1'b1);
    chk("bp_valid_after_rdy", 32'(sv2), 0);
    chk("bp_ovr_sticky", 32'(ov2), 1);

    // Completion on the same edge as the handshake
    do_reset();
    cyc(PW, 1'b1, 1'b0);
    cyc(PW, 1'b1, 1'b0);
    chk("same_first", 32'(s2), 2);
    cyc(PX, 1'b1, 1'b0);
    cyc(PX, 1'b1, 1'b1);
    chk("same_sum", 32'(s2), 4);
    chk("same_valid", 32'(sv2), 1);
    chk("same_ovr", 32'(ov2), 0);

    // Malformed input: {v&w}, w, w, w -> 0+1+1+1 = 3
    do_reset();
    cyc(5'b00011, 1'b1, 1'b1);
    chk("bad_err_set", 32'(oe4), 1);
    for (int i = 0; i < 3; i++) cyc(PW, 1'b1, 1'b1);
    chk("bad_sum", 32'(s4), 3);
    chk("bad_valid", 32'(sv4), 1);
    for (int i = 0; i < 3; i++) cyc(PW, 1'b1, 1'b1);
    chk("bad_err_sticky", 32'(oe4), 1);

    // Reset mid-window: partial 8 discarded, reset wins over an enabled sample
    do_reset();
    cyc(PZ, 1'b1, 1'b1);
    cyc(PZ, 1'b1, 1'b1);
    reset = 1'b1;
    cyc(PZ, 1'b1, 1'b1);
    reset = 1'b0;
    chk("mid_rst_sum", 32'(s4), 0);
    chk("mid_rst_valid", 32'(sv4), 0);
    chk("mid_rst_flags", 32'({ov4, oe4}), 0);
    for (int i = 0; i < 4; i++) cyc(PW, 1'b1, 1'b1);
    chk("mid_rst_result", 32'(s4), 4);
    chk("mid_rst_result_valid", 32'(sv4), 1);

    // Throughput with WINDOW=1: new sum every enabled cycle
    do_reset();
    cyc(PX, 1'b1, 1'b1);
    chk("w1_a", 32'(s1), 2);
    cyc(PY, 1'b1, 1'b1);
    chk("w1_b", 32'(s1), 3);
    cyc(PZ, 1'b1, 1'b1);
    chk("w1_c", 32'(s1), 4);
    chk("w1_valid", 32'(sv1), 1);
    cyc(5'b0, 1'b0, 1'b1);
    chk("w1_idle", 32'(sv1), 0);
    chk("w1_ovr", 32'(ov1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
